// File: rtl/nonce_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : nonce_tx_queue
// Purpose  : Buffers golden nonces from the hashing core in a circular FIFO
//            and hands them one at a time to a serial transmitter using a
//            send strobe plus busy handshake.
// Ports    : clk         - single clock, rising edge
//            reset_n     - asynchronous active-low reset
//            nonce_in    - 32-bit nonce from the hashing core
//            nonce_valid - one-cycle strobe qualifying nonce_in
//            flush       - new-work strobe, discards queued nonces
//            tx_busy     - busy indication from the serial transmitter
//            tx_word     - word offered to the transmitter
//            tx_send     - one-cycle send strobe to the transmitter
//            count       - entries queued, excluding the in-flight word
//            overflow    - sticky: a nonce was dropped on a full queue
// Config   : define NONCE_DEDUP_EN to drop a nonce equal to the last
//            accepted one (flush forgets the last accepted value).
// Revision : 1.0 - initial release
// ============================================================================
module nonce_tx_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              nonce_in,
  input  logic                     nonce_valid,
  input  logic                     flush,
  input  logic                     tx_busy,
  output logic [31:0]              tx_word,
  output logic                     tx_send,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        candidate;
  logic        drop_full;
  logic        is_dup;

  // Pointers carry one extra bit so full and empty can be told apart
  // without a separate occupancy counter.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // The head leaves the queue on the IDLE->SEND transition only; empty
  // gating keeps stale storage from ever reaching tx_word.
  assign pop = (state == IDLE) && !empty && !tx_busy;

  // Flush wins over a same-cycle nonce; a duplicate is silently ignored.
  assign candidate = nonce_valid && !flush && !is_dup;

  // A full queue still accepts when the head leaves in the same cycle.
  assign push      = candidate && (!full || pop);
  assign drop_full = candidate && full && !pop;

  assign count = wr_ptr - rd_ptr;

`ifdef NONCE_DEDUP_EN
  logic [31:0] last_nonce;
  logic        last_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_nonce <= 32'd0;
      last_valid <= 1'b0;
    end else if (flush) begin
      last_valid <= 1'b0;
    end else if (push) begin
      last_nonce <= nonce_in;
      last_valid <= 1'b1;
    end
  end

  assign is_dup = last_valid && (nonce_in == last_nonce);
`else
  assign is_dup = 1'b0;
`endif

  // Storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= nonce_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      // push is never set together with flush, so wr_ptr is stable here
      // and the queue ends up empty even if the head pops this cycle.
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop_full) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_word <= 32'd0;
    end else if (pop) begin
      tx_word <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tx_send    = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          state_next = SEND;
        end
      end
      SEND: begin
        tx_send    = 1'b1;
        state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_next = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_nonce_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_nonce_tx_queue
// Purpose  : Self-checking bench for nonce_tx_queue. A queue-based reference
//            model predicts count, overflow, tx_send and tx_word each cycle;
//            a simple transmitter model drives tx_busy.
// Config   : honours NONCE_DEDUP_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nonce_tx_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

`ifdef NONCE_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  // Transmit handshake stages of the reference model
  localparam int PH_READY      = 0;
  localparam int PH_STROBE     = 1;
  localparam int PH_AWAIT_RISE = 2;
  localparam int PH_AWAIT_FALL = 3;

  typedef logic [31:0] word_q_t[$];

  logic          clk         = 1'b0;
  logic          reset_n     = 1'b1;
  logic [31:0]   nonce_in    = 32'd0;
  logic          nonce_valid = 1'b0;
  logic          flush       = 1'b0;
  logic          tx_busy     = 1'b0;
  logic [31:0]   tx_word;
  logic          tx_send;
  logic [CW-1:0] count;
  logic          overflow;

  always #5 clk = ~clk;

  nonce_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .nonce_in    (nonce_in),
    .nonce_valid (nonce_valid),
    .flush       (flush),
    .tx_busy     (tx_busy),
    .tx_word     (tx_word),
    .tx_send     (tx_send),
    .count       (count),
    .overflow    (overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] mq[$];
  bit          m_ovf;
  int          m_phase;
  logic [31:0] m_word;
  logic [31:0] m_last;
  bit          m_last_v;

  // transmitter model knobs
  bit hold_busy = 1'b0;
  int rise_dly  = 1;
  int hi_len    = 3;
  int rise_in   = 0;
  int high_left = 0;

  logic [31:0] sent[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf    = 1'b0;
    m_phase  = PH_READY;
    m_word   = 32'd0;
    m_last   = 32'd0;
    m_last_v = 1'b0;
  endtask

  // One clock of behaviour from the rules: the head leaves first, then a
  // new nonce is accepted if there is room, then flush empties the queue.
  task automatic model_step();
    bit          pop;
    bit          dup;
    logic [31:0] head;
    pop = (m_phase == PH_READY) && (mq.size() > 0) && !tx_busy;
    dup = DEDUP && m_last_v && (nonce_in == m_last);
    case (m_phase)
      PH_READY:      if (pop) m_phase = PH_STROBE;
      PH_STROBE:     m_phase = PH_AWAIT_RISE;
      PH_AWAIT_RISE: if (tx_busy) m_phase = PH_AWAIT_FALL;
      default:       if (!tx_busy) m_phase = PH_READY;
    endcase
    if (pop) begin
      head   = mq.pop_front();
      m_word = head;
    end
    if (nonce_valid && !flush && !dup) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(nonce_in);
        m_last   = nonce_in;
        m_last_v = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (flush) begin
      mq.delete();
      m_last_v = 1'b0;
    end
  endtask

  task automatic drive_busy();
    if (hold_busy) begin
      tx_busy   = 1'b1;
      rise_in   = 0;
      high_left = 0;
    end else if (rise_in > 0) begin
      rise_in--;
      if (rise_in == 0) begin
        tx_busy   = 1'b1;
        high_left = hi_len;
      end
    end else if (high_left > 0) begin
      high_left--;
      if (high_left == 0) tx_busy = 1'b0;
    end else begin
      tx_busy = 1'b0;
    end
    if (m_phase == PH_STROBE) rise_in = rise_dly;
  endtask

  task automatic cycle();
    @(negedge clk);
    check("count",    32'(count),    32'(mq.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("tx_send",  32'(tx_send),  32'(m_phase == PH_STROBE));
    check("tx_word",  tx_word,       m_word);
    if (tx_send === 1'b1) sent.push_back(tx_word);
    if (reset_n) model_step();
    @(posedge clk);
    #1;
    nonce_valid = 1'b0;
    flush       = 1'b0;
    drive_busy();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic push(input logic [31:0] w);
    nonce_valid = 1'b1;
    nonce_in    = w;
    cycle();
  endtask

  // Asserts reset between clock edges and checks the outputs respond
  // before any edge arrives.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_tx_send",  32'(tx_send),  32'd0);
    check("rst_tx_word",  tx_word,       32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n     = 1'b1;
    nonce_valid = 1'b0;
    flush       = 1'b0;
    drive_busy();
    sent.delete();
  endtask

  task automatic wait_phase(input int ph, input int limit);
    int k = 0;
    while (m_phase != ph && k < limit) begin
      cycle();
      k++;
    end
    check("wait_bound", 32'(m_phase == ph), 32'd1);
  endtask

  task automatic check_sent(input string tag, input word_q_t exp);
    check({tag, "_num"}, 32'(sent.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      check(tag, (i < sent.size()) ? sent[i] : 32'hxxxxxxxx, exp[i]);
    end
  endtask

  initial begin
    word_q_t e;
    model_reset();
    do_reset();

    // single nonce, transmitter rises one cycle after the strobe
    rise_dly = 1;
    hi_len   = 3;
    push(32'hDEADBEEF);
    run(100);
    e = {};
    e.push_back(32'hDEADBEEF);
    check_sent("single", e);
    check("single_count", 32'(count), 32'd0);

    // fill past capacity with the transmitter busy
    hold_busy = 1'b1;
    do_reset();
    for (int i = 1; i <= 9; i++) push(32'(i));
    check("fill_count",    32'(count),    32'd8);
    check("fill_overflow", 32'(overflow), 32'd1);
    hold_busy = 1'b0;
    run(150);
    e = {};
    for (int i = 1; i <= 8; i++) e.push_back(32'(i));
    check_sent("fill_order", e);

    // push into a full queue on the same cycle as the head leaves
    hold_busy = 1'b1;
    do_reset();
    for (int i = 1; i <= 8; i++) push(32'h100 + 32'(i));
    check("full_count", 32'(count), 32'd8);
    hold_busy   = 1'b0;
    tx_busy     = 1'b0;
    nonce_valid = 1'b1;
    nonce_in    = 32'hA;
    cycle();
    check("pp_count",    32'(count),    32'd8);
    check("pp_overflow", 32'(overflow), 32'd0);
    run(150);
    e = {};
    for (int i = 1; i <= 8; i++) e.push_back(32'h100 + 32'(i));
    e.push_back(32'hA);
    check_sent("pp_order", e);

    // flush while the first word is in flight
    do_reset();
    push(32'h11);
    push(32'h22);
    push(32'h33);
    flush = 1'b1;
    cycle();
    run(60);
    e = {};
    e.push_back(32'h11);
    check_sent("flush", e);
    check("flush_count", 32'(count), 32'd0);

    // reset in the middle of the busy-low wait with words queued
    do_reset();
    hi_len = 40;
    for (int i = 1; i <= 4; i++) push(32'h200 + 32'(i));
    wait_phase(PH_AWAIT_FALL, 20);
    check("mid_count", 32'(count), 32'd3);
    do_reset();
    run(60);
    check("post_rst_sends", 32'(sent.size()), 32'd0);
    hi_len = 3;

    // back-to-back repeated nonce
    do_reset();
    push(32'h55);
    push(32'h55);
    push(32'h66);
    run(60);
    e = {};
    e.push_back(32'h55);
    if (!DEDUP) e.push_back(32'h55);
    e.push_back(32'h66);
    check_sent("dedup", e);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 2) hold_busy = !hold_busy;
      rise_dly = $urandom_range(1, 3);
      hi_len   = $urandom_range(1, 4);
      if ($urandom_range(0, 99) < 45) begin
        nonce_valid = 1'b1;
        nonce_in    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      end
      flush = ($urandom_range(0, 99) < 3);
      cycle();
    end
    hold_busy = 1'b0;
    run(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got simulation still running expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
